// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer for a 9-bit ISA.
// It owns the PC, the IR, the Z flag and an 8x8 register file. The ALU sits
// outside this block and is driven from the registered alu_* outputs.
module cpu_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_valid,
   input  logic [8:0] imem_data,
   output logic [7:0] alu_in1,
   output logic [7:0] alu_in2,
   output logic [2:0] alu_op,
   output logic [5:0] alu_imm6,
   output logic       alu_imm_mode,
   input  logic [7:0] alu_out,
   input  logic       alu_zero,
   output logic       busy,
   output logic       done,
   input  logic [2:0] dbg_sel,
   output logic [7:0] dbg_data
);

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] rd;
      logic [2:0] rs;
   } insn_t;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

   localparam logic [2:0] OP_LDI = 3'b011;
   localparam logic [2:0] OP_BZ  = 3'b100;
   localparam logic [2:0] OP_HLT = 3'b111;

   state_t          state;
   logic [7:0]      pc;
   insn_t           ir;
   logic            z;
   logic [7:0][7:0] rf;

   logic [7:0] pc_inc;
   logic [7:0] pc_br;

   // BZ target: 6-bit signed offset {rd,rs}, wraps mod 256 like the increment
   assign pc_inc    = pc + 8'd1;
   assign pc_br     = pc + {{2{ir.rd[2]}}, ir.rd, ir.rs};
   assign imem_addr = pc;
   assign dbg_data  = rf[dbg_sel];

   // Sequencer: state, architectural registers and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         ir           <= '0;
         z            <= 1'b0;
         rf           <= '0;
         alu_in1      <= '0;
         alu_in2      <= '0;
         alu_op       <= '0;
         alu_imm6     <= '0;
         alu_imm_mode <= 1'b0;
         imem_req     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  pc       <= RESET_PC;
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            FETCH: begin
               if (imem_valid) begin
                  ir       <= insn_t'(imem_data);
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               alu_in1      <= rf[ir.rd];
               alu_in2      <= rf[ir.rs];
               alu_imm6     <= {ir.rd, ir.rs};
               // only the four ALU opcodes reach the ALU; control ops issue ADD/reg
               alu_op       <= ir.op[2] ? 3'b000 : ir.op;
               alu_imm_mode <= (ir.op == OP_LDI);
               state        <= EXEC;
            end
            EXEC: begin
               state <= WB;
            end
            WB: begin
               if (ir.op == OP_HLT) begin
                  state <= HALT;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  if (!ir.op[2]) begin
                     rf[ir.rd] <= alu_out;
                     z         <= alu_zero;
                     pc        <= pc_inc;
                  end else if (ir.op == OP_BZ) begin
                     pc <= z ? pc_br : pc_inc;
                  end else begin
                     pc <= pc_inc;
                  end
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: behavioural ALU, program memory with a
// programmable fetch wait, and one task per scenario.
module tb_cpu_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_valid;
   logic [8:0] imem_data;
   logic [7:0] alu_in1, alu_in2, alu_out;
   logic [2:0] alu_op;
   logic [5:0] alu_imm6;
   logic       alu_imm_mode, alu_zero;
   logic       busy, done;
   logic [2:0] dbg_sel = 3'd0;
   logic [7:0] dbg_data;

   int tests = 0;
   int fails = 0;
   int wait_cycles = 0;
   int fcnt = 0;
   logic [8:0] prog [256];

   cpu_ctrl #(.RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_imm6(alu_imm6), .alu_imm_mode(alu_imm_mode),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .busy(busy), .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // ALU model; LDI loads the low three immediate bits (the rs field)
   always_comb begin
      alu_out = 8'h00;
      case (alu_op)
         3'd0: alu_out = alu_in1 + alu_in2;
         3'd1: alu_out = alu_in1 - alu_in2;
         3'd2: alu_out = alu_in1 & alu_in2;
         3'd3: alu_out = alu_imm_mode ? {5'b0, alu_imm6[2:0]} : 8'h00;
         default: alu_out = 8'h00;
      endcase
   end
   assign alu_zero = (alu_out == 8'h00);

   // Instruction memory answers after wait_cycles cycles of an open request
   always @(posedge clk) begin
      if (!imem_req || imem_valid) fcnt <= 0;
      else fcnt <= fcnt + 1;
   end
   assign imem_valid = imem_req && (fcnt >= wait_cycles);
   assign imem_data  = prog[imem_addr];

   function automatic logic [8:0] ins(input int op, input int rd, input int rs);
      logic [8:0] w;
      w = {op[2:0], rd[2:0], rs[2:0]};
      return w;
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = ins(7, 0, 0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic rd(input int i, output logic [7:0] v);
      dbg_sel = i[2:0];
      #1;
      v = dbg_data;
   endtask

   task automatic run_until_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      tests++; if ({imem_req, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_ctl req/busy/done=%b want 000", {imem_req, busy, done}); end
      tests++; if ({alu_in1, alu_in2, alu_op, alu_imm6, alu_imm_mode} !== 26'd0) begin fails++; $display("FAIL reset_alu got %h/%h/%h/%h/%b want 0", alu_in1, alu_in2, alu_op, alu_imm6, alu_imm_mode); end
      tests++; if (imem_addr !== 8'h00 || dut.z !== 1'b0) begin fails++; $display("FAIL reset_pc_z pc=%h z=%b want 00/0", imem_addr, dut.z); end
      for (int r = 0; r < 8; r++) begin
         rd(r, v);
         tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_rf R%0d=%h want 00", r, v); end
      end
   endtask

   // LDI R1,5; LDI R2,3; SUB R1,R2; HALT with zero-wait fetches
   task automatic test_program();
      logic [7:0] v;
      do_reset();
      wait_cycles = 0;
      clear_prog();
      prog[0] = ins(3, 1, 5);
      prog[1] = ins(3, 2, 3);
      prog[2] = ins(1, 1, 2);
      prog[3] = ins(7, 0, 0);
      pulse_start();
      tests++; if (imem_req !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL prog_fetch req=%b busy=%b want 1/1", imem_req, busy); end
      for (int i = 1; i <= 15; i++) begin
         tick(1);
         if (i == 2) begin
            tests++; if ({alu_op, alu_imm_mode, alu_imm6} !== {3'd3, 1'b1, 6'd13}) begin fails++; $display("FAIL prog_ldi_dec op=%0d imm=%b imm6=%0d want 3/1/13", alu_op, alu_imm_mode, alu_imm6); end
         end
      end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL prog_done_early done=%b want 0 at cycle 15", done); end
      tick(1);
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL prog_done_16 done=%b busy=%b want 1/0", done, busy); end
      rd(1, v);
      tests++; if (v !== 8'd2) begin fails++; $display("FAIL prog_r1 got %0d want 2", v); end
      rd(2, v);
      tests++; if (v !== 8'd3) begin fails++; $display("FAIL prog_r2 got %0d want 3", v); end
      tests++; if (dut.z !== 1'b0) begin fails++; $display("FAIL prog_z got %b want 0", dut.z); end
      tests++; if (alu_op !== 3'd0 || alu_imm_mode !== 1'b0) begin fails++; $display("FAIL prog_halt_alu op=%0d imm=%b want 0/0", alu_op, alu_imm_mode); end
   endtask

   // BZ +2 at PC=4: taken lands on HALT at 6, not taken on HALT at 5
   task automatic test_bz(input bit zset);
      bit ok;
      do_reset();
      clear_prog();
      prog[0] = ins(3, 1, 5);
      prog[1] = zset ? ins(1, 1, 1) : ins(3, 2, 3);
      prog[2] = zset ? ins(5, 0, 0) : ins(1, 1, 2);
      prog[3] = ins(6, 0, 0);
      prog[4] = ins(4, 0, 2);
      pulse_start();
      run_until_done(100, ok);
      tests++; if (!ok) begin fails++; $display("FAIL bz_timeout z=%b done never rose", zset); end
      tests++; if (dut.z !== zset) begin fails++; $display("FAIL bz_zflag got %b want %b", dut.z, zset); end
      tests++; if (imem_addr !== (zset ? 8'd6 : 8'd5)) begin fails++; $display("FAIL bz_target z=%b pc=%0d want %0d", zset, imem_addr, zset ? 6 : 5); end
   endtask

   // Fetch held 3 extra cycles: request/address stable, WB lands 3 late
   task automatic test_wait();
      logic [7:0] v;
      bit ok;
      do_reset();
      wait_cycles = 3;
      clear_prog();
      prog[0] = ins(3, 3, 6);
      pulse_start();
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin fails++; $display("FAIL wait_stable c%0d req=%b addr=%h want 1/00", i, imem_req, imem_addr); end
      end
      tick(3);
      rd(3, v);
      tests++; if (v !== 8'd0) begin fails++; $display("FAIL wait_early R3=%0d want 0 before cycle 7", v); end
      tick(1);
      rd(3, v);
      tests++; if (v !== 8'd6 || imem_addr !== 8'd1) begin fails++; $display("FAIL wait_wb R3=%0d pc=%0d want 6/1", v, imem_addr); end
      run_until_done(100, ok);
      tests++; if (!ok) begin fails++; $display("FAIL wait_timeout done never rose"); end
      wait_cycles = 0;
   endtask

   // PC wrap both ways plus a zero-offset BZ spin
   task automatic test_wrap();
      bit ok;
      do_reset();
      clear_prog();
      prog[0] = ins(1, 0, 0);
      pulse_start();
      run_until_done(100, ok);
      tests++; if (!ok || dut.z !== 1'b1) begin fails++; $display("FAIL wrap_setup ok=%b z=%b want 1/1", ok, dut.z); end
      prog[0]   = ins(4, 7, 7);
      prog[255] = ins(5, 0, 0);
      pulse_start();
      tick(4);
      tests++; if (imem_addr !== 8'hFF) begin fails++; $display("FAIL wrap_bz_neg pc=%h want FF", imem_addr); end
      tick(4);
      tests++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL wrap_nop pc=%h want 00", imem_addr); end
      prog[0] = ins(4, 0, 0);
      tick(4);
      tests++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL wrap_spin1 pc=%h want 00", imem_addr); end
      tick(4);
      tests++; if (imem_addr !== 8'h00 || busy !== 1'b1) begin fails++; $display("FAIL wrap_spin2 pc=%h busy=%b want 00/1", imem_addr, busy); end
   endtask

   // Reset in WB of an ADD, then mid-FETCH together with start
   task automatic test_reset_abort();
      logic [7:0] v;
      bit ok;
      do_reset();
      clear_prog();
      prog[0] = ins(3, 4, 7);
      prog[1] = ins(0, 4, 4);
      pulse_start();
      tick(7);
      rd(4, v);
      tests++; if (v !== 8'd7 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre R4=%0d busy=%b want 7/1", v, busy); end
      reset = 1'b1;
      tick(1);
      rd(4, v);
      tests++; if (v !== 8'd0) begin fails++; $display("FAIL abort_wb R4=%0d want 0 (cleared, ADD not written)", v); end
      tests++; if ({imem_req, busy, done, imem_addr, alu_in1, alu_op} !== 30'd0) begin fails++; $display("FAIL abort_wb_out req=%b busy=%b done=%b pc=%h in1=%h op=%0d want 0", imem_req, busy, done, imem_addr, alu_in1, alu_op); end
      reset = 1'b0;
      wait_cycles = 100;
      pulse_start();
      tick(2);
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL abort_fetch_pre req=%b want 1", imem_req); end
      reset = 1'b1;
      start = 1'b1;
      tick(1);
      tests++; if (imem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_fetch req=%b busy=%b want 0/0", imem_req, busy); end
      reset = 1'b0;
      start = 1'b0;
      tick(1);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle busy=%b want 0", busy); end
      wait_cycles = 0;
      pulse_start();
      run_until_done(100, ok);
      rd(4, v);
      tests++; if (!ok || v !== 8'd14) begin fails++; $display("FAIL abort_rerun ok=%b R4=%0d want 1/14", ok, v); end
   endtask

   // start while busy is dropped; start from HALT restarts with regs intact
   task automatic test_start_busy();
      logic [7:0] v;
      bit ok;
      do_reset();
      clear_prog();
      prog[0] = ins(3, 5, 4);
      prog[1] = ins(3, 6, 2);
      pulse_start();
      tick(5);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tests++; if (busy !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL busy_start busy=%b req=%b want 1/0", busy, imem_req); end
      tick(2);
      tests++; if (imem_addr !== 8'd2) begin fails++; $display("FAIL busy_pc pc=%0d want 2", imem_addr); end
      run_until_done(100, ok);
      tests++; if (!ok) begin fails++; $display("FAIL busy_timeout done never rose"); end
      prog[0] = ins(3, 5, 1);
      pulse_start();
      tests++; if ({imem_req, busy, done, imem_addr} !== {3'b110, 8'h00}) begin fails++; $display("FAIL halt_restart req=%b busy=%b done=%b pc=%h want 1/1/0/00", imem_req, busy, done, imem_addr); end
      rd(5, v);
      tests++; if (v !== 8'd4) begin fails++; $display("FAIL halt_keep_r5 got %0d want 4", v); end
      rd(6, v);
      tests++; if (v !== 8'd2) begin fails++; $display("FAIL halt_keep_r6 got %0d want 2", v); end
   endtask

   initial begin
      clear_prog();
      test_reset();
      test_program();
      test_bz(1'b1);
      test_bz(1'b0);
      test_wait();
      test_wrap();
      test_reset_abort();
      test_start_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, start address for program counter on reset and on start.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  pulse; begins execution from RESET_PC when in IDLE or HALT.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  8  fetch address, equal to current PC.
REQ-007 imem_valid  input  1  instruction memory returns imem_data this cycle.
REQ-008 imem_data  input  9  instruction word: [8:6] opcode, [5:3] rd, [2:0] rs/imm.
REQ-009 alu_in1  output  8  R[rd].
REQ-010 alu_in2  output  8  R[rs].
REQ-011 alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 LDI.
REQ-012 alu_imm6  output  6  instruction bits [5:0].
REQ-013 alu_imm_mode  output  1  high only for LDI.
REQ-014 alu_out  input  8  ALU result, combinational from the alu_* outputs.
REQ-015 alu_zero  input  1  ALU zero flag for alu_out.
REQ-016 busy  output  1  high in FETCH, DECODE, EXEC, WB.
REQ-017 done  output  1  high in HALT.
REQ-018 dbg_sel  input  3  register index for debug read.
REQ-019 dbg_data  output  8  combinational R[dbg_sel].

Function
REQ-020 Internal state: PC[7:0], IR[8:0], Z flag, and an 8x8 register file R0..R7, all writable.
REQ-021 FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-022 IDLE/HALT + start=1 -> PC=RESET_PC, go to FETCH.
REQ-023 start is ignored while busy=1.
REQ-024 FETCH: imem_req=1, imem_addr=PC, held stable until imem_valid=1; on that edge IR<=imem_data, go to DECODE.
REQ-025 imem_valid outside FETCH is ignored.
REQ-026 DECODE: latch R[IR[5:3]] and R[IR[2:0]] into the alu_in1/alu_in2 registers; latch alu_op, alu_imm6 and alu_imm_mode; go to EXEC.
REQ-027 EXEC: alu_* outputs stable; go to WB.
REQ-028 WB, opcode 000-011: R[rd]<=alu_out; Z<=alu_zero; PC<=PC+1 (mod 256); go to FETCH.
REQ-029 WB, opcode 100 (BZ): no register write and Z unchanged; if Z=1, PC<=PC+sign-extended IR[5:0] (mod 256), else PC<=PC+1.
REQ-030 WB, opcode 101/110 (NOP): PC<=PC+1; no other state change.
REQ-031 WB, opcode 111 (HALT): PC unchanged; go to HALT.
REQ-032 Execution latency: 4 cycles per instruction when imem_valid is asserted in the first FETCH cycle; each added wait cycle adds 1.
REQ-033 PC wraps from 8'hFF to 8'h00 without a stall or flag.
REQ-034 A BZ offset of 0 with Z=1 leaves PC unchanged (intentional spin).
REQ-035 alu_op/alu_imm_mode shall be 000/0 for opcodes 100-111.
REQ-036 alu_* outputs hold their last values outside DECODE updates.

Reset
REQ-037 reset=1 at a clock edge: state=IDLE, PC=RESET_PC, IR=0, Z=0, R0..R7=0, alu_* outputs=0, imem_req=0, busy=0, done=0.
REQ-038 Reset has priority over start and imem_valid, and aborts any state including mid-FETCH; imem_req is low in the cycle after the reset edge.
REQ-039 While reset=1, no register-file write occurs.

Verification
REQ-040 Program LDI R1,5; LDI R2,3; SUB R1,R2; HALT, imem_valid same cycle -> R1=2, R2=3, Z=0, done=1 exactly 16 cycles after start.
REQ-041 SUB R1,R1, then BZ +2 at PC=4 -> Z=1, next imem_addr=6; the same sequence with Z=0 -> next imem_addr=5.
REQ-042 imem_valid delayed 3 cycles in FETCH -> imem_req and imem_addr stable throughout; instruction completes 3 cycles later than nominal.
REQ-043 PC=8'hFF NOP -> next imem_addr=8'h00; BZ -1 at PC=0 with Z=1 -> next imem_addr=8'hFF.
REQ-044 reset asserted in FETCH and again in WB of an ADD -> target register unchanged, all outputs at reset values, state IDLE.
REQ-045 start pulsed while busy -> ignored; start pulsed in HALT -> PC=RESET_PC, new FETCH, register contents preserved.
